// File: rtl/spi_ram_pkg.sv
// Shared types and constants for the SPI-slave RAM front end.
package spi_ram_pkg;

    localparam int WORD_W = 10;
    localparam int DATA_W = 8;

    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

    // One-hot encoding keeps next-state decode to single-bit tests.
    typedef enum logic [4:0] {
        IDLE      = 5'b00001,
        CHK_CMD   = 5'b00010,
        WRITE     = 5'b00100,
        READ_ADD  = 5'b01000,
        READ_DATA = 5'b10000
    } state_t;

endpackage

// File: rtl/spi_miso_serializer.sv
// Loads the RAM read byte on the first tx_valid while armed and shifts it out MSB first.
module spi_miso_serializer #(
    parameter int DATA_W = spi_ram_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_arm,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_valid,
    output logic              o_miso,
    output logic              o_done
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_active;
    logic              r_loaded;
    logic              r_miso;

    assign o_done = r_active && (r_cnt == LAST);
    assign o_miso = r_miso;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift  <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_loaded <= 1'b0;
            r_miso   <= 1'b0;
        end else if (i_clear) begin
            r_shift  <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_loaded <= 1'b0;
            r_miso   <= 1'b0;
        end else if (i_arm && !r_loaded && i_tx_valid) begin
            // MSB goes straight to the pin; the rest waits in the shifter.
            r_loaded <= 1'b1;
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_miso   <= i_tx_data[DATA_W-1];
            r_shift  <= {i_tx_data[DATA_W-2:0], 1'b0};
        end else if (r_active) begin
            if (o_done) begin
                r_active <= 1'b0;
                r_miso   <= 1'b0;
            end else begin
                r_miso  <= r_shift[DATA_W-1];
                r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                r_cnt   <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_ram_slave_ctrl.sv
// SPI-slave front end: deserialises MOSI command words for the RAM and returns
// read bytes on MISO through spi_miso_serializer.
module spi_ram_slave_ctrl #(
    parameter int WORD_W = spi_ram_pkg::WORD_W,
    parameter int DATA_W = spi_ram_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);

    import spi_ram_pkg::*;

    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] STROBE_AT = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] HOLD_AT   = CNT_W'(WORD_W);

    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [WORD_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_rd_addr_done;
    logic              w_shifting;
    logic              w_strobe;
    logic              w_arm;
    logic              w_tx_done;

    assign w_shifting = (r_state inside {WRITE, READ_ADD, READ_DATA}) && !SS_n;
    assign w_strobe   = w_shifting && (r_cnt == STROBE_AT);
    assign w_arm      = (r_state == READ_DATA) && (r_cnt == HOLD_AT) && !SS_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (SS_n) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_next_state = CHK_CMD;
                // Reads are steered by the flag, not the second command bit.
                CHK_CMD: begin
                    if (MOSI == WR_ADDR[1]) w_next_state = WRITE;
                    else if (r_rd_addr_done) w_next_state = READ_DATA;
                    else                     w_next_state = READ_ADD;
                end
                WRITE, READ_ADD, READ_DATA: w_next_state = r_state;
                default: w_next_state = IDLE;
            endcase
        end
    end

    // r_cnt: 0..STROBE_AT-1 while shifting, STROBE_AT on the strobe cycle, HOLD_AT once the frame is done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt          <= '0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_rd_addr_done <= 1'b0;
        end else begin
            r_rx_valid <= w_strobe;
            if (SS_n) begin
                r_cnt <= '0;
            end else if (r_state == CHK_CMD) begin
                r_rx_data[WORD_W-1] <= MOSI;
                r_cnt               <= '0;
            end else if (w_shifting && (r_cnt < STROBE_AT)) begin
                r_rx_data[WORD_W-2:0] <= {r_rx_data[WORD_W-3:0], MOSI};
                r_cnt                 <= r_cnt + 1'b1;
            end else if (w_strobe) begin
                r_cnt <= HOLD_AT;
            end

            if (w_strobe && (r_state == READ_ADD)) r_rd_addr_done <= 1'b1;
            else if (w_tx_done)                    r_rd_addr_done <= 1'b0;
        end
    end

    spi_miso_serializer #(
        .DATA_W (DATA_W)
    ) u_miso (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (SS_n),
        .i_arm      (w_arm),
        .i_tx_data  (tx_data),
        .i_tx_valid (tx_valid),
        .o_miso     (MISO),
        .o_done     (w_tx_done)
    );

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

endmodule
